// File: rtl/rdma_rc_pkg.sv
// Shared RC PDU receive-path definitions: FSM encoding, QP states, opcode ranges
// and response error bit positions used by the arbiter and the parser.
package rdma_rc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } rx_state_e;

  localparam logic [2:0] QPS_RESET = 3'd0;
  localparam logic [2:0] QPS_INIT  = 3'd1;
  localparam logic [2:0] QPS_RTR   = 3'd2;
  localparam logic [2:0] QPS_RTS   = 3'd3;
  localparam logic [2:0] QPS_ERR   = 3'd4;

  // RC opcodes live in 0x00..0x1F; the data-carrying sub-range ends at 0x05.
  localparam logic [7:0] OPC_RC_MIN       = 8'h00;
  localparam logic [7:0] OPC_RC_DATA_MAX  = 8'h05;
  localparam logic [7:0] OPC_RC_MAX       = 8'h1F;

  localparam int ERR_OPCODE_BIT  = 0;
  localparam int ERR_QPN_BIT     = 1;
  localparam int ERR_TIMEOUT_BIT = 2;
  localparam int ERR_BITS        = 3;

endpackage

// File: rtl/rdma_rc_rr_arbiter.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping.
module rdma_rc_rr_arbiter #(
  parameter int N_PORTS = 4,
  localparam int PORT_W = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [PORT_W-1:0]  ptr,
  output logic [N_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]  gnt_idx,
  output logic               any_req
);

  localparam logic [PORT_W:0] NP = (PORT_W+1)'(N_PORTS);

  logic [PORT_W:0] s;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_req = 1'b0;
    s       = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      // One extra bit lets the modulo be a single conditional subtract.
      s = {1'b0, ptr} + (PORT_W+1)'(i);
      if (s >= NP) s = s - NP;
      if (!any_req && req[s[PORT_W-1:0]]) begin
        any_req = 1'b1;
        gnt_idx = s[PORT_W-1:0];
      end
    end
    if (any_req) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/rdma_rc_pdu_rx_arbiter.sv
// Shares one RC PDU parser among N_PORTS ingress channels: round-robin accept,
// one-cycle parser issue, timed wait for done, tagged response, error counters.
module rdma_rc_pdu_rx_arbiter
  import rdma_rc_pkg::*;
#(
  parameter int N_PORTS        = 4,
  parameter int DATA_WIDTH     = 64,
  parameter int OPCODE_WIDTH   = 8,
  parameter int QPN_WIDTH      = 16,
  parameter int PSN_WIDTH      = 24,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ERR_CNT_WIDTH  = 8,
  localparam int PORT_W        = $clog2(N_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     in_data,
  input  logic [N_PORTS-1:0]                in_valid,
  output logic [N_PORTS-1:0]                in_ready,
  output logic [DATA_WIDTH-1:0]             prs_pdu_data,
  output logic                              prs_pdu_valid,
  input  logic [OPCODE_WIDTH-1:0]           prs_opcode,
  input  logic [QPN_WIDTH-1:0]              prs_qpn,
  input  logic [PSN_WIDTH-1:0]              prs_psn,
  input  logic                              prs_is_data,
  input  logic                              prs_is_ctrl,
  input  logic                              prs_opcode_err,
  input  logic                              prs_qpn_err,
  input  logic                              prs_done,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [PORT_W-1:0]                 resp_port,
  output logic [OPCODE_WIDTH-1:0]           resp_opcode,
  output logic [QPN_WIDTH-1:0]              resp_qpn,
  output logic [PSN_WIDTH-1:0]              resp_psn,
  output logic                              resp_is_data,
  output logic                              resp_is_ctrl,
  output logic                              resp_opcode_err,
  output logic                              resp_qpn_err,
  output logic                              resp_timeout,
  output logic [N_PORTS*ERR_CNT_WIDTH-1:0]  err_cnt,
  output logic                              busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(N_PORTS - 1);

  typedef struct packed {
    logic [PORT_W-1:0]       port;
    logic [OPCODE_WIDTH-1:0] opcode;
    logic [QPN_WIDTH-1:0]    qpn;
    logic [PSN_WIDTH-1:0]    psn;
    logic                    is_data;
    logic                    is_ctrl;
    logic                    opcode_err;
    logic                    qpn_err;
    logic                    timeout;
  } resp_t;

  rx_state_e                                 state;
  logic [PORT_W-1:0]                         rr_ptr;
  logic [PORT_W-1:0]                         win_q;
  logic [DATA_WIDTH-1:0]                     data_q;
  logic [TMO_W-1:0]                          tmo_cnt;
  resp_t                                     resp_q;
  logic [N_PORTS-1:0][ERR_CNT_WIDTH-1:0]     err_q;
  logic [N_PORTS-1:0][DATA_WIDTH-1:0]        in_data_a;
  logic [N_PORTS-1:0]                        gnt;
  logic [PORT_W-1:0]                         gnt_idx;
  logic                                      any_req;
  logic [ERR_BITS-1:0]                       resp_err;

  assign in_data_a = in_data;

  rdma_rc_rr_arbiter #(.N_PORTS(N_PORTS)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // Only IDLE may accept, which keeps exactly one PDU in flight.
  assign in_ready = (state == S_IDLE) ? gnt : '0;

  always_comb begin
    resp_err                  = '0;
    resp_err[ERR_OPCODE_BIT]  = resp_q.opcode_err;
    resp_err[ERR_QPN_BIT]     = resp_q.qpn_err;
    resp_err[ERR_TIMEOUT_BIT] = resp_q.timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      win_q         <= '0;
      data_q        <= '0;
      prs_pdu_valid <= 1'b0;
      tmo_cnt       <= '0;
      resp_valid    <= 1'b0;
      resp_q        <= '0;
      err_q         <= '0;
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          win_q         <= gnt_idx;
          data_q        <= in_data_a[gnt_idx];
          prs_pdu_valid <= 1'b1;
          state         <= S_ISSUE;
        end
        S_ISSUE: begin
          prs_pdu_valid <= 1'b0;
          tmo_cnt       <= '0;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          if (prs_done) begin
            resp_q.port       <= win_q;
            resp_q.opcode     <= prs_opcode;
            resp_q.qpn        <= prs_qpn;
            resp_q.psn        <= prs_psn;
            resp_q.is_data    <= prs_is_data;
            resp_q.is_ctrl    <= prs_is_ctrl;
            resp_q.opcode_err <= prs_opcode_err;
            resp_q.qpn_err    <= prs_qpn_err;
            resp_q.timeout    <= 1'b0;
            resp_valid        <= 1'b1;
            state             <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            resp_q         <= '0;
            resp_q.port    <= win_q;
            resp_q.timeout <= 1'b1;
            resp_valid     <= 1'b1;
            state          <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_RESP: if (resp_ready) begin
          resp_valid <= 1'b0;
          rr_ptr     <= (win_q == LAST_PORT) ? '0 : win_q + 1'b1;
          if (|resp_err && err_q[win_q] != '1)
            err_q[win_q] <= err_q[win_q] + 1'b1;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign prs_pdu_data    = data_q;
  assign resp_port       = resp_q.port;
  assign resp_opcode     = resp_q.opcode;
  assign resp_qpn        = resp_q.qpn;
  assign resp_psn        = resp_q.psn;
  assign resp_is_data    = resp_q.is_data;
  assign resp_is_ctrl    = resp_q.is_ctrl;
  assign resp_opcode_err = resp_q.opcode_err;
  assign resp_qpn_err    = resp_q.qpn_err;
  assign resp_timeout    = resp_q.timeout;
  assign err_cnt         = err_q;
  assign busy            = (state != S_IDLE);

endmodule
